// File: rtl/cmd_frame_decoder.sv
// Command-frame decoder: SYNC, OPCODE, PARAM bytes (big-endian), XOR checksum.
// Emits a one-hot command strobe with parameter, or a coded error pulse.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | waiting for SYNC_BYTE, other bytes ignored
// S_OPCODE | expecting opcode byte (1..N_CMDS)
// S_PARAM  | shifting in PARAM_BYTES parameter bytes
// S_CHECK  | expecting checksum byte
module cmd_frame_decoder #(
    parameter int          N_CMDS         = 4,
    parameter int          PARAM_BYTES    = 2,
    parameter logic [7:0]  SYNC_BYTE      = 8'h00,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_valid,
    output logic                     o_wait_cmd,
    output logic                     o_cmd_valid,
    output logic [N_CMDS-1:0]        o_cmd,
    output logic [8*PARAM_BYTES-1:0] o_cmd_param,
    output logic                     o_error,
    output logic [1:0]               o_err_code
);

    localparam int PW = 8 * PARAM_BYTES;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_BYTE = 3'(PARAM_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_OPCODE, S_PARAM, S_CHECK} state_t;

    state_t          state, state_n;
    logic [7:0]      opcode_q;
    logic [7:0]      chk_q;
    logic [2:0]      byte_cnt;
    logic [PW-1:0]   shreg;
    logic [CW-1:0]   to_cnt;
    logic            timed_out;
    logic            op_ok;
    logic            take_op;
    logic            take_param;
    logic            accept;
    logic            reject;
    logic [1:0]      rej_code;

    // The count reaches TIMEOUT_CYCLES on this edge; an arriving byte wins.
    assign timed_out  = (state != S_IDLE) && !i_rx_valid && (to_cnt == TO_LAST);
    assign op_ok      = (i_rx_data != 8'd0) && (i_rx_data <= 8'(N_CMDS));
    assign o_wait_cmd = (state != S_IDLE);

    always_comb begin
        state_n    = state;
        take_op    = 1'b0;
        take_param = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        rej_code   = 2'd0;
        case (state)
            S_IDLE: begin
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) state_n = S_OPCODE;
            end
            S_OPCODE: begin
                if (i_rx_valid) begin
                    if (op_ok) begin
                        take_op = 1'b1;
                        state_n = S_PARAM;
                    end else begin
                        reject   = 1'b1;
                        rej_code = 2'd1;
                        state_n  = S_IDLE;
                    end
                end
            end
            S_PARAM: begin
                if (i_rx_valid) begin
                    take_param = 1'b1;
                    if (byte_cnt == LAST_BYTE) state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (i_rx_valid) begin
                    state_n = S_IDLE;
                    if (i_rx_data == chk_q) begin
                        accept = 1'b1;
                    end else begin
                        reject   = 1'b1;
                        rej_code = 2'd2;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (timed_out) begin
            reject   = 1'b1;
            rej_code = 2'd3;
            state_n  = S_IDLE;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            opcode_q    <= '0;
            chk_q       <= '0;
            byte_cnt    <= '0;
            shreg       <= '0;
            to_cnt      <= '0;
            o_cmd_valid <= 1'b0;
            o_cmd       <= '0;
            o_cmd_param <= '0;
            o_error     <= 1'b0;
            o_err_code  <= 2'd0;
        end else begin
            if (i_rx_valid || (state == S_IDLE)) to_cnt <= '0;
            else                                 to_cnt <= to_cnt + CW'(1);
            if (take_op) begin
                opcode_q <= i_rx_data;
                chk_q    <= i_rx_data;
                byte_cnt <= '0;
            end
            if (take_param) begin
                shreg    <= PW'({shreg, i_rx_data});
                chk_q    <= chk_q ^ i_rx_data;
                byte_cnt <= byte_cnt + 3'd1;
            end
            o_cmd_valid <= accept;
            o_error     <= reject;
            o_cmd       <= accept ? (N_CMDS'(1) << (opcode_q - 8'd1)) : '0;
            if (accept) o_cmd_param <= shreg;
            if (reject) o_err_code  <= rej_code;
        end
    end

endmodule

// File: doc/cmd_frame_decoder.md
# cmd_frame_decoder

Parametrised command-frame decoder: consumes a byte stream from the UART receiver (`i_rx_data`/`i_rx_valid`) and turns framed packets into one-hot command strobes with a multi-byte parameter. Successor to the nibble-encoded single-byte command unit. Adds:
- configurable command count and parameter length;
- an XOR checksum;
- an inter-byte timeout;
- coded error reporting.

It sits between the UART receiver and the sampling/decimation control logic.

## Interface
Parameters:
- `N_CMDS`, 4 — number of commands, 1..8; opcode k (1..N_CMDS) selects `o_cmd[k-1]`.
- `PARAM_BYTES`, 2 — parameter length in bytes, 1..4.
- `SYNC_BYTE`, 8'h00 — frame start marker.
- `TIMEOUT_CYCLES`, 1000000 — maximum idle clocks between bytes inside a frame, ≥2.

Ports:
- `i_clock`  in  1 — clock.
- `i_reset`  in  1 — reset; synchronous, active-high.
- `i_rx_data`  in  8 — received byte; valid only when `i_rx_valid` is high.
- `i_rx_valid`  in  1 — one-cycle strobe per received byte.
- `o_wait_cmd`  out  1 — high while a frame is in progress (any state except IDLE).
- `o_cmd_valid`  out  1 — one-cycle pulse when a frame is accepted.
- `o_cmd`  out  N_CMDS — one-hot command; nonzero only while `o_cmd_valid` is high.
- `o_cmd_param`  out  8*PARAM_BYTES — parameter of the last accepted frame; holds until the next accepted frame.
- `o_error`  out  1 — one-cycle pulse when a frame is rejected.
- `o_err_code`  out  2 — reason for the last rejection: 0 none, 1 bad opcode, 2 checksum, 3 timeout; holds until the next error.

## Operation
- Frame format: SYNC_BYTE, OPCODE, PARAM[0..PARAM_BYTES-1], CHK.
  - PARAM is big-endian: the first byte received is the MSB.
  - CHK must equal OPCODE XOR every PARAM byte.
- FSM states: IDLE, OPCODE, PARAM, CHECK.
  - IDLE: on a byte equal to SYNC_BYTE → OPCODE. Any other byte is ignored silently.
  - OPCODE:
    - Byte in 1..N_CMDS → latch the opcode, seed the running XOR with this byte, clear the byte counter, go to PARAM.
    - Otherwise → error code 1, go to IDLE.
  - PARAM:
    - Each byte shifts into the parameter shift register and XORs into the running checksum.
    - After the PARAM_BYTES-th byte → CHECK.
  - CHECK, on a byte:
    - Byte equals the running XOR → copy the shift register to `o_cmd_param`, pulse `o_cmd_valid`, set `o_cmd[opcode-1]`, go to IDLE.
    - Otherwise → error code 2, go to IDLE. `o_cmd_param` is unchanged.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to OPCODE and on every accepted byte; increments each cycle in OPCODE, PARAM and CHECK.
  - On reaching TIMEOUT_CYCLES → error code 3, go to IDLE.
  - If `i_rx_valid` arrives in the same cycle the count is reached, the byte wins and no timeout is raised.
- No resynchronisation mid-frame: a SYNC_BYTE value seen in OPCODE, PARAM or CHECK is treated as data.
- `i_reset` forces IDLE regardless of state. A frame interrupted by reset produces no pulse.
- Reset values:
  - FSM state IDLE.
  - `o_wait_cmd`, `o_cmd_valid`, `o_error` = 0.
  - `o_cmd` = 0, `o_cmd_param` = 0, `o_err_code` = 0.
  - Internal counters and checksum = 0.

## Timing
- `o_wait_cmd` is decoded from the state register. It rises the cycle after the sync byte is sampled and falls the cycle after the terminating byte, the error or the timeout.
- Latency:
  - Checksum byte sampled at edge t → `o_cmd_valid`/`o_cmd` high for exactly cycle t+1, with `o_cmd_param` already updated at t+1.
  - Any error detected at edge t → `o_error` high for cycle t+1, with `o_err_code` updated at t+1.
- `o_cmd_valid` and `o_error` are never high in the same cycle.
- Back-to-back operation: a sync byte may arrive in the cycle right after the terminating byte. It is accepted because the FSM is already in IDLE.
- Minimum frame spacing: no gap is required, as bytes may arrive on consecutive cycles.

## Test plan
All scenarios use N_CMDS=4, PARAM_BYTES=2 unless stated otherwise.
- Good frame 00,02,12,34,24 → one pulse of `o_cmd_valid` with `o_cmd`=4'b0010 and `o_cmd_param`=16'h1234, `o_error` stays 0; `o_wait_cmd` high from the cycle after 00 until the cycle after 24.
- Bad opcode 00,07 → `o_error` pulse with `o_err_code`=1, then return to IDLE; a following good frame 00,01,00,05,04 → `o_cmd`=4'b0001, `o_cmd_param`=16'h0005.
- Bad checksum 00,03,AA,55,00 → `o_err_code`=2, no `o_cmd_valid`, and `o_cmd_param` keeps its previous value.
- Timeout with TIMEOUT_CYCLES=16: send 00,04,12 then silence → `o_error` with `o_err_code`=3 exactly 16 cycles after 12 is sampled. A byte arriving on the 16th cycle instead is accepted with no error.
- Back-to-back good frames on consecutive cycles, with 00 and 02 inside the parameter field → both frames accepted; the in-frame 00 is taken as data.
- `i_reset` asserted after 00,02,12 → all outputs return to their reset values and no pulse is produced; a following full frame decodes correctly.
